uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the data-memory bus of `single_cycle_rv`, downstream of the core's store path. The core's store path is the ALU address, `rs2` write data and MemWrite. Stores to the TXDATA register enqueue bytes into a small FIFO. A baud-rate FSM serialises them as 8N1 frames on `uart_tx`. The status and divisor registers are readable combinationally so that single-cycle loads complete in the same cycle.

---
 rtl/uart_tx_mmio_pkg.sv | 23 ++
 rtl/uart_tx_mmio_if.sv | 19 +
 rtl/uart_tx_mmio_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_mmio.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_mmio_pkg.sv
// Shared MMIO definitions for the single_cycle_rv peripherals: register
// offsets, STATUS bit positions and the UART transmitter state encoding.
package rv_mmio_pkg;

  localparam logic [3:0] OFF_TXDATA   = 4'h0;
  localparam logic [3:0] OFF_STATUS   = 4'h4;
  localparam logic [3:0] OFF_BAUD_DIV = 4'h8;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 4;
  localparam int unsigned STAT_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory bus as seen by an MMIO slave: the core drives address, store
// data and strobe; the slave answers with a hit flag and combinational data.
interface uart_tx_mmio_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_we;
  logic        bus_hit;
  logic [31:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_we,
    input  bus_hit, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we,
    output bus_hit, bus_rdata
  );
endinterface

// File: rtl/uart_tx_mmio_sync_fifo.sv
// Single-clock FIFO with a combinational head; a push while full is taken
// only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUD_DIV registers,
// TX FIFO and a baud-rate FSM with zero-gap back-to-back frames.
module uart_tx_mmio
  import rv_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_mmio_if.slave  bus,
  output logic           uart_tx
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    off;
  logic          hit, wr_en;
  logic          wr_txdata, wr_status, wr_div;
  logic [15:0]   div_q, div_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    occ;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   dlat_q, dlat_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          start_frame;

  logic          unused_bits;
  assign unused_bits = &{1'b0, bus.bus_wdata[31:16], bus.bus_addr[1:0]};

  assign off       = {bus.bus_addr[3:2], 2'b00};
  assign hit       = (bus.bus_addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en     = bus.bus_we && hit;
  assign wr_txdata = wr_en && (off == OFF_TXDATA);
  assign wr_status = wr_en && (off == OFF_STATUS);
  assign wr_div    = wr_en && (off == OFF_BAUD_DIV);

  assign bus.bus_hit = hit;
  assign uart_tx     = tx_q;
  assign fifo_push   = wr_txdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (bus.bus_wdata[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    if (32'(fifo_count) > 32'd15) occ = 4'hF;
    else                          occ = 4'(fifo_count);
  end

  always_comb begin
    bus.bus_rdata = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          bus.bus_rdata[STAT_BUSY]                     = (state_q != ST_IDLE);
          bus.bus_rdata[STAT_FULL]                     = fifo_full;
          bus.bus_rdata[STAT_EMPTY]                    = fifo_empty;
          bus.bus_rdata[STAT_OVF]                      = ovf_q;
          bus.bus_rdata[STAT_CNT_LSB +: STAT_CNT_W]    = occ;
        end
        OFF_BAUD_DIV: bus.bus_rdata[15:0] = div_q;
        default:      bus.bus_rdata = '0;
      endcase
    end
  end

  always_comb begin
    div_d = div_q;
    if (wr_div) div_d = (bus.bus_wdata[15:0] == '0) ? 16'd1 : bus.bus_wdata[15:0];
  end

  // A dropped byte is one the FIFO refuses: full with no pop this cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_status && bus.bus_wdata[STAT_OVF])          ovf_d = 1'b0;
    else if (wr_txdata && fifo_full && !fifo_pop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DEFAULT_DIV;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dlat_d      = dlat_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          cnt_d   = dlat_q - 16'd1;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = dlat_q - 16'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            start_frame = 1'b1;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Shared frame launch from IDLE and from the end of STOP; the divisor
    // is latched here so mid-frame BAUD_DIV writes apply to the next frame.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dout;
      dlat_d   = div_q;
      cnt_d    = div_q - 16'd1;
      state_d  = ST_START;
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dlat_q  <= DEFAULT_DIV;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dlat_q  <= dlat_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register access, frame timing, FIFO
// overflow, divisor latching, address decode and asynchronous reset.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_DV = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic uart_tx;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_mmio_if bus_if ();

  uart_tx_mmio #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (8),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus_if.slave),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_if.bus_addr  = a;
    bus_if.bus_wdata = d;
    bus_if.bus_we    = 1'b1;
    @(posedge clk);
    #1;
    bus_if.bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_if.bus_addr = a;
    bus_if.bus_we   = 1'b0;
    #1;
    d = bus_if.bus_rdata;
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame starts (tx low) right after the edge on which cyc becomes t0.
  task automatic check_frame(input int unsigned t0, input int unsigned div,
                             input logic [7:0] b, input bit every, input string tag);
    for (int unsigned j = 0; j < 10 * div; j++) begin
      int unsigned s;
      logic        e;
      s = j / div;
      if (s == 0)      e = 1'b0;
      else if (s == 9) e = 1'b1;
      else             e = b[s-1];
      if (every || (j % div) == div / 2) begin
        wait_cyc(t0 + j);
        chk(tag, {31'd0, uart_tx}, {31'd0, e});
      end
    end
  endtask

  logic [31:0] rd;
  int unsigned t0;

  initial begin
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;
    bus_if.bus_we    = 1'b0;

    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    chk("rst_tx", {31'd0, uart_tx}, 32'd1);
    bus_read(A_ST, rd); chk("rst_status", rd, 32'h0000_0004);
    chk("rst_hit", {31'd0, bus_if.bus_hit}, 32'd1);
    bus_read(A_DV, rd); chk("rst_div", rd, 32'd434);
    bus_read(BASE + 32'h20, rd); chk("nohit_rdata", rd, 32'd0);
    chk("nohit_hit", {31'd0, bus_if.bus_hit}, 32'd0);

    // Single frame, DIV=4, 0x55
    bus_write(A_DV, 32'd4);
    bus_read(A_DV, rd); chk("div4", rd, 32'd4);
    bus_write(A_TX, 32'h55);
    t0 = cyc + 1;
    chk("pre_start_tx", {31'd0, uart_tx}, 32'd1);
    bus_read(A_ST, rd); chk("queued_status", rd, 32'h0000_0010);
    bus_read(A_TX, rd); chk("txdata_reads0", rd, 32'd0);
    wait_cyc(t0);
    bus_read(A_ST, rd); chk("busy_start", rd, 32'h0000_0005);
    check_frame(t0, 4, 8'h55, 1'b1, "frame55");
    bus_read(A_ST, rd); chk("busy_stop", rd, 32'h0000_0005);
    wait_cyc(t0 + 40);
    bus_read(A_ST, rd); chk("idle_after55", rd, 32'h0000_0004);
    chk("idle_tx55", {31'd0, uart_tx}, 32'd1);

    // Back-to-back, DIV=2
    bus_write(A_DV, 32'd2);
    bus_write(A_TX, 32'hA5);
    t0 = cyc + 1;
    bus_write(A_TX, 32'h3C);
    check_frame(t0, 2, 8'hA5, 1'b1, "b2b_A5");
    check_frame(t0 + 20, 2, 8'h3C, 1'b1, "b2b_3C");
    wait_cyc(t0 + 40);
    bus_read(A_ST, rd); chk("b2b_idle", rd, 32'h0000_0004);

    // Overflow, DIV=100, bytes 0..9
    bus_write(A_DV, 32'd100);
    bus_write(A_TX, 32'h00);
    t0 = cyc + 1;
    for (int i = 1; i < 10; i++) bus_write(A_TX, 32'(i));
    bus_read(A_ST, rd); chk("ovf_status", rd, 32'h0000_008B);
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, rd); chk("ovf_cleared", rd, 32'h0000_0083);
    for (int f = 0; f < 9; f++)
      check_frame(t0 + 32'(f) * 1000, 100, 8'(f), 1'b0, "ovf_tx");
    wait_cyc(t0 + 9000);
    bus_read(A_ST, rd); chk("ovf_drained", rd, 32'h0000_0004);

    // Mid-frame divisor change
    bus_write(A_DV, 32'd4);
    bus_write(A_TX, 32'h0F);
    t0 = cyc + 1;
    bus_write(A_TX, 32'hF0);
    bus_write(A_DV, 32'd0);
    bus_read(A_DV, rd); chk("div0_as1", rd, 32'd1);
    check_frame(t0, 4, 8'h0F, 1'b0, "div_old");
    check_frame(t0 + 40, 1, 8'hF0, 1'b1, "div_new");
    wait_cyc(t0 + 50);
    bus_read(A_ST, rd); chk("div_idle", rd, 32'h0000_0004);

    // Decode: out-of-window writes and reserved offset
    bus_if.bus_addr = BASE + 32'h10; #1;
    chk("alias_hit", {31'd0, bus_if.bus_hit}, 32'd0);
    bus_write(BASE + 32'h10, 32'h77);
    bus_write(BASE + 32'h18, 32'h55);
    bus_write(A_RS, 32'hFFFF_FFFF);
    bus_read(A_RS, rd); chk("reserved_rd", rd, 32'd0);
    bus_read(A_DV, rd); chk("alias_div", rd, 32'd1);
    bus_read(A_ST, rd); chk("alias_status", rd, 32'h0000_0004);
    chk("alias_tx", {31'd0, uart_tx}, 32'd1);

    // Reset mid-frame with bytes queued
    bus_write(A_DV, 32'd4);
    bus_write(A_TX, 32'h11);
    t0 = cyc + 1;
    bus_write(A_TX, 32'h22);
    bus_write(A_TX, 32'h33);
    wait_cyc(t0 + 10);
    chk("pre_rst_tx", {31'd0, uart_tx}, 32'd0);
    bus_read(A_ST, rd); chk("pre_rst_status", rd, 32'h0000_0021);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'd0, uart_tx}, 32'd1);
    bus_read(A_ST, rd); chk("in_rst_status", rd, 32'h0000_0004);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    bus_read(A_ST, rd); chk("post_rst_status", rd, 32'h0000_0004);
    bus_read(A_DV, rd); chk("post_rst_div", rd, 32'd434);
    t0 = cyc;
    for (int unsigned k = 1; k <= 20; k += 5) begin
      wait_cyc(t0 + k);
      chk("post_rst_idle", {31'd0, uart_tx}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
